// File: rtl/keypad_request_queue_if.sv
// ---------------------------------------------------------------------------
// keypad_request_queue_if
//
// Request handshake between the keypad request queue and the motion
// controller. The queue drives a floor number with a valid flag, and the
// controller answers with ready. A transfer happens on any clock edge where
// both valid and ready are high.
//
// Signals:
//   req_valid  queue -> controller  req_floor holds a live request
//   req_floor  queue -> controller  floor at the head of the queue
//   req_ready  controller -> queue  controller takes req_floor this cycle
//
// Modports:
//   master  the request queue (drives valid/floor, samples ready)
//   slave   the motion controller (samples valid/floor, drives ready)
// ---------------------------------------------------------------------------
interface keypad_request_queue_if #(
  parameter int FLOOR_W = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [FLOOR_W-1:0] req_floor;

  modport master (
    output req_valid,
    output req_floor,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_ready
  );
endinterface

// File: rtl/keypad_request_queue.sv
// ---------------------------------------------------------------------------
// keypad_request_queue
//
// Turns debounced keypad presses into an ordered stream of floor requests for
// the motion controller.
//
// The design has three stages:
//   1. Key capture FSM: a key code must stay stable for HOLD_CYCLES cycles
//      before it produces a single one-cycle key event. A held key gives
//      exactly one event and never auto-repeats.
//   2. Key decode: the event code is registered as a floor request, an
//      emergency-stop command (4'hF) or a clear-all command (4'hE).
//   3. Request queue: floor requests are checked against the pending bitmap
//      and pushed into a FIFO. The FIFO head goes out on the request
//      handshake. Head entries whose floor was already served on the way are
//      discarded automatically.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   buttonBus      key code from the scanner, valid while a key is held
//   pressed        low while a key is held
//   req_if         request handshake (master side: valid/floor out, ready in)
//   arrived        one-cycle pulse, car reached arrived_floor
//   arrived_floor  floor the car reached
//   pending        floors requested and not yet reached
//   count          FIFO occupancy, 0..DEPTH
//   estop          emergency stop latched
//   overflow       one-cycle pulse, a new request was dropped on a full FIFO
// ---------------------------------------------------------------------------
module keypad_request_queue #(
  parameter  int NUM_FLOORS  = 8,
  parameter  int DEPTH       = 8,
  parameter  int HOLD_CYCLES = 4,
  localparam int FLOOR_W     = $clog2(NUM_FLOORS),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              buttonBus,
  input  logic                    pressed,
  keypad_request_queue_if.master  req_if,
  input  logic                    arrived,
  input  logic [FLOOR_W-1:0]      arrived_floor,
  output logic [NUM_FLOORS-1:0]   pending,
  output logic [CNT_W-1:0]        count,
  output logic                    estop,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [3:0] CODE_ESTOP = 4'hF;
  localparam logic [3:0] CODE_CLEAR = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_REL
  } cap_state_e;

  // Key capture state
  cap_state_e        state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              key_event_q, key_event_d;
  logic [3:0]        event_code_q, event_code_d;

  // Decoded command, one cycle after the key event
  logic               cmd_floor_q, cmd_floor_d;
  logic [FLOOR_W-1:0] cmd_floor_code_q, cmd_floor_code_d;
  logic               cmd_estop_q, cmd_estop_d;
  logic               cmd_clear_q, cmd_clear_d;

  // Queue state
  logic [FLOOR_W-1:0]    fifo_q [DEPTH];
  logic [FLOOR_W-1:0]    fifo_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  estop_q, estop_d;
  logic                  overflow_q, overflow_d;

  // Queue helper signals
  logic [FLOOR_W-1:0] head_floor;
  logic               head_live;
  logic               not_empty;
  logic               full;
  logic               req_valid_int;
  logic               stale_pop;
  logic               pop;
  logic               req_new;
  logic               push;
  logic               arrival_ok;

  // Key capture: a glitch (release during HOLD) returns to IDLE with no
  // event; a code change restarts the stability count on the new code.
  // The event fires once the count has reached HOLD_CYCLES, so with
  // HOLD_CYCLES==1 it fires on the first HOLD cycle.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    hold_cnt_d   = hold_cnt_q;
    key_event_d  = 1'b0;
    event_code_d = event_code_q;
    case (state_q)
      IDLE: begin
        if (!pressed) begin
          code_d     = buttonBus;
          hold_cnt_d = HC_W'(1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (pressed) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (buttonBus != code_q) begin
          code_d     = buttonBus;
          hold_cnt_d = HC_W'(1);
        end else if (hold_cnt_q == HC_W'(HOLD_CYCLES)) begin
          key_event_d  = 1'b1;
          event_code_d = code_q;
          hold_cnt_d   = '0;
          state_d      = WAIT_REL;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      WAIT_REL: begin
        if (pressed) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Decode the key event into one of the three commands. Codes that are
  // neither floors nor service keys leave all three flags low.
  always_comb begin
    cmd_floor_d      = key_event_q && (32'(event_code_q) < 32'(NUM_FLOORS));
    cmd_floor_code_d = event_code_q[FLOOR_W-1:0];
    cmd_estop_d      = key_event_q && (event_code_q == CODE_ESTOP);
    cmd_clear_d      = key_event_q && (event_code_q == CODE_CLEAR);
  end

  // Head of queue. An entry whose pending bit has already been cleared was
  // served en route, so it is popped without ever being shown as valid.
  // Emergency stop freezes the head completely, stale entries included.
  always_comb begin
    head_floor    = fifo_q[rd_ptr_q];
    head_live     = pending_q[head_floor];
    not_empty     = (count_q != '0);
    full          = (count_q == CNT_W'(DEPTH));
    req_valid_int = not_empty && head_live && !estop_q;
    stale_pop     = not_empty && !head_live && !estop_q;
    pop           = (req_valid_int && req_if.req_ready) || stale_pop;
    req_new       = cmd_floor_q && !pending_q[cmd_floor_code_q];
    push          = req_new && !full;
    arrival_ok    = arrived && (32'(arrived_floor) < 32'(NUM_FLOORS));
  end

  // Queue update. Fullness is judged on the registered count, so a pop in
  // the same cycle never makes room for a push. An arrival is applied before
  // a push so a fresh request for the floor just reached still survives.
  // Clear-all overrides everything else in its cycle.
  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pending_d  = pending_q;
    estop_d    = estop_q || cmd_estop_q;
    overflow_d = req_new && full;

    if (arrival_ok) begin
      pending_d[arrived_floor] = 1'b0;
    end

    if (push) begin
      fifo_d[wr_ptr_q]            = cmd_floor_code_q;
      wr_ptr_d                    = wr_ptr_q + PTR_W'(1);
      pending_d[cmd_floor_code_q] = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (cmd_clear_q) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pending_d  = '0;
      estop_d    = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // All state flops. Reset also discards any key capture in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      code_q           <= '0;
      hold_cnt_q       <= '0;
      key_event_q      <= 1'b0;
      event_code_q     <= '0;
      cmd_floor_q      <= 1'b0;
      cmd_floor_code_q <= '0;
      cmd_estop_q      <= 1'b0;
      cmd_clear_q      <= 1'b0;
      fifo_q           <= '{default: '0};
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      pending_q        <= '0;
      estop_q          <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      code_q           <= code_d;
      hold_cnt_q       <= hold_cnt_d;
      key_event_q      <= key_event_d;
      event_code_q     <= event_code_d;
      cmd_floor_q      <= cmd_floor_d;
      cmd_floor_code_q <= cmd_floor_code_d;
      cmd_estop_q      <= cmd_estop_d;
      cmd_clear_q      <= cmd_clear_d;
      fifo_q           <= fifo_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      pending_q        <= pending_d;
      estop_q          <= estop_d;
      overflow_q       <= overflow_d;
    end
  end

  assign req_if.req_valid = req_valid_int;
  assign req_if.req_floor = head_floor;
  assign pending          = pending_q;
  assign count            = count_q;
  assign estop            = estop_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_keypad_request_queue.sv
// ---------------------------------------------------------------------------
// tb_keypad_request_queue
//
// Directed bench for keypad_request_queue with default parameters
// (8 floors, 8-entry FIFO, 4-cycle hold). The main process presses keys and
// pushes the floors it expects to see handed over into a scoreboard queue;
// a monitor process pops that queue whenever a handshake transfer occurs
// and compares the floor. Static state (count, pending, estop, ...) is
// compared directly from the main process.
// ---------------------------------------------------------------------------
module tb_keypad_request_queue;

  localparam int NUM_FLOORS  = 8;
  localparam int DEPTH       = 8;
  localparam int HOLD_CYCLES = 4;
  localparam int FLOOR_W     = 3;
  localparam int CNT_W       = 4;
  localparam int PRESS_HOLD  = HOLD_CYCLES + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            buttonBus;
  logic                  pressed;
  logic                  arrived;
  logic [FLOOR_W-1:0]    arrived_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic [CNT_W-1:0]      count;
  logic                  estop;
  logic                  overflow;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int ovf_seen   = 0;
  logic [FLOOR_W-1:0] exp_q[$];

  keypad_request_queue_if #(.FLOOR_W(FLOOR_W)) req_if ();

  keypad_request_queue #(
    .NUM_FLOORS (NUM_FLOORS),
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttonBus    (buttonBus),
    .pressed      (pressed),
    .req_if       (req_if),
    .arrived      (arrived),
    .arrived_floor(arrived_floor),
    .pending      (pending),
    .count        (count),
    .estop        (estop),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a key for the given number of cycles, release, and let the
  // capture/decode/queue pipeline settle
  task automatic applyStimulus(input logic [3:0] code, input int hold);
    buttonBus = code;
    pressed   = 1'b0;
    tick(hold);
    pressed   = 1'b1;
    buttonBus = 4'h0;
    tick(4);
  endtask

  task automatic arrive(input logic [FLOOR_W-1:0] f);
    arrived       = 1'b1;
    arrived_floor = f;
    tick(1);
    arrived       = 1'b0;
    tick(1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    exp_q.delete();
    ovf_seen = 0;
  endtask

  // Let the controller drain the FIFO, bounded by a cycle budget
  task automatic waitDrain(input string name, input int budget);
    int k;
    k = 0;
    while (count != '0 && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput(name, 32'(count), 32'd0);
  endtask

  // Scoreboard monitor: every handshake transfer must match the oldest
  // expected floor
  always @(negedge clk) begin
    if (!rst && req_if.req_valid && req_if.req_ready) begin
      if (exp_q.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $display("[TB] FAIL unexpected_transfer: got floor %0d, expected no transfer",
                 req_if.req_floor);
      end else begin
        checkOutput("transfer_floor", 32'(req_if.req_floor), 32'(exp_q.pop_front()));
      end
    end
    if (!rst && overflow) begin
      ovf_seen++;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    pressed          = 1'b1;
    buttonBus        = 4'h0;
    arrived          = 1'b0;
    arrived_floor    = '0;
    req_if.req_ready = 1'b0;
    tick(2);

    $display("[TB] Reset values");
    checkOutput("rst_req_valid", 32'(req_if.req_valid), 32'd0);
    checkOutput("rst_req_floor", 32'(req_if.req_floor), 32'd0);
    checkOutput("rst_pending",   32'(pending),          32'd0);
    checkOutput("rst_count",     32'(count),            32'd0);
    checkOutput("rst_estop",     32'(estop),            32'd0);
    checkOutput("rst_overflow",  32'(overflow),         32'd0);
    rst = 1'b0;
    tick(1);

    // Latency: valid appears HOLD_CYCLES+3 edges after the key goes down
    $display("[TB] Single press, latency and duplicate");
    buttonBus = 4'd3;
    pressed   = 1'b0;
    tick(HOLD_CYCLES + 2);
    pressed   = 1'b1;
    buttonBus = 4'h0;
    checkOutput("t1_valid_early", 32'(req_if.req_valid), 32'd0);
    tick(1);
    checkOutput("t1_valid",   32'(req_if.req_valid), 32'd1);
    checkOutput("t1_floor",   32'(req_if.req_floor), 32'd3);
    checkOutput("t1_pending", 32'(pending),          32'h08);
    checkOutput("t1_count",   32'(count),            32'd1);
    tick(3);
    applyStimulus(4'd3, PRESS_HOLD);
    tick(2);
    checkOutput("t1_dup_count",   32'(count),   32'd1);
    checkOutput("t1_dup_pending", 32'(pending), 32'h08);
    checkOutput("t1_dup_ovf",     32'(ovf_seen), 32'd0);
    exp_q.push_back(3'd3);
    req_if.req_ready = 1'b1;
    waitDrain("t1_drain", 10);
    req_if.req_ready = 1'b0;
    checkOutput("t1_pending_after_pop", 32'(pending), 32'h08);
    arrive(3'd3);
    checkOutput("t1_pending_after_arrive", 32'(pending), 32'h00);
    checkOutput("t1_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] Glitch reject and code change");
    doReset();
    applyStimulus(4'd5, 2);
    tick(6);
    checkOutput("t2_glitch_count",   32'(count),   32'd0);
    checkOutput("t2_glitch_pending", 32'(pending), 32'h00);
    buttonBus = 4'd2;
    pressed   = 1'b0;
    tick(2);
    buttonBus = 4'd6;
    tick(PRESS_HOLD);
    pressed   = 1'b1;
    buttonBus = 4'h0;
    tick(5);
    checkOutput("t2_change_count",   32'(count),            32'd1);
    checkOutput("t2_change_floor",   32'(req_if.req_floor), 32'd6);
    checkOutput("t2_change_pending", 32'(pending),          32'h40);
    exp_q.push_back(3'd6);
    req_if.req_ready = 1'b1;
    waitDrain("t2_drain", 10);
    req_if.req_ready = 1'b0;
    arrive(3'd6);
    checkOutput("t2_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] Ordering with a stale entry");
    doReset();
    applyStimulus(4'd1, PRESS_HOLD);
    applyStimulus(4'd2, PRESS_HOLD);
    applyStimulus(4'd3, PRESS_HOLD);
    applyStimulus(4'd4, PRESS_HOLD);
    checkOutput("t3_count",   32'(count),            32'd4);
    checkOutput("t3_pending", 32'(pending),          32'h1E);
    checkOutput("t3_head",    32'(req_if.req_floor), 32'd1);
    arrive(3'd2);
    checkOutput("t3_pending_arrive2", 32'(pending), 32'h1A);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd4);
    req_if.req_ready = 1'b1;
    waitDrain("t3_drain", 20);
    req_if.req_ready = 1'b0;
    checkOutput("t3_pending_after_pops", 32'(pending), 32'h1A);
    arrive(3'd1);
    arrive(3'd3);
    arrive(3'd4);
    checkOutput("t3_pending_final", 32'(pending), 32'h00);
    checkOutput("t3_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] Full FIFO and overflow");
    doReset();
    for (int f = 0; f < NUM_FLOORS; f++) begin
      applyStimulus(4'(f), PRESS_HOLD);
    end
    checkOutput("t4_count_full", 32'(count),   32'd8);
    checkOutput("t4_pending",    32'(pending), 32'hFF);
    arrive(3'd7);
    checkOutput("t4_pending_arrive7", 32'(pending), 32'h7F);
    applyStimulus(4'd7, PRESS_HOLD);
    tick(2);
    checkOutput("t4_overflow_pulses", 32'(ovf_seen), 32'd1);
    checkOutput("t4_count_after_ovf", 32'(count),    32'd8);
    checkOutput("t4_pending_after",   32'(pending),  32'h7F);
    applyStimulus(4'hA, PRESS_HOLD);
    tick(2);
    checkOutput("t4_ignored_ovf",   32'(ovf_seen), 32'd1);
    checkOutput("t4_ignored_count", 32'(count),    32'd8);

    $display("[TB] Emergency stop and clear-all");
    doReset();
    applyStimulus(4'd1, PRESS_HOLD);
    applyStimulus(4'd2, PRESS_HOLD);
    applyStimulus(4'hF, PRESS_HOLD);
    checkOutput("t5_estop", 32'(estop), 32'd1);
    checkOutput("t5_count", 32'(count), 32'd2);
    req_if.req_ready = 1'b1;
    repeat (10) begin
      checkOutput("t5_valid_blocked", 32'(req_if.req_valid), 32'd0);
      tick(1);
    end
    checkOutput("t5_count_held", 32'(count), 32'd2);
    applyStimulus(4'd6, PRESS_HOLD);
    checkOutput("t5_count_queued", 32'(count),   32'd3);
    checkOutput("t5_pending",      32'(pending), 32'h46);
    applyStimulus(4'hE, PRESS_HOLD);
    checkOutput("t5_clear_count",   32'(count),   32'd0);
    checkOutput("t5_clear_pending", 32'(pending), 32'h00);
    checkOutput("t5_clear_estop",   32'(estop),   32'd0);
    req_if.req_ready = 1'b0;
    checkOutput("t5_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("[TB] Asynchronous reset mid-capture");
    doReset();
    applyStimulus(4'd1, PRESS_HOLD);
    applyStimulus(4'd2, PRESS_HOLD);
    applyStimulus(4'd3, PRESS_HOLD);
    checkOutput("t6_count_before", 32'(count), 32'd3);
    buttonBus = 4'd5;
    pressed   = 1'b0;
    tick(2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_count",     32'(count),            32'd0);
    checkOutput("t6_async_pending",   32'(pending),          32'h00);
    checkOutput("t6_async_valid",     32'(req_if.req_valid), 32'd0);
    checkOutput("t6_async_floor",     32'(req_if.req_floor), 32'd0);
    checkOutput("t6_async_estop",     32'(estop),            32'd0);
    checkOutput("t6_async_overflow",  32'(overflow),         32'd0);
    pressed   = 1'b1;
    buttonBus = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(12);
    checkOutput("t6_no_event_count",   32'(count),   32'd0);
    checkOutput("t6_no_event_pending", 32'(pending), 32'h00);
    applyStimulus(4'd5, PRESS_HOLD);
    checkOutput("t6_fresh_count",   32'(count),   32'd1);
    checkOutput("t6_fresh_pending", 32'(pending), 32'h20);
    checkOutput("t6_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_request_queue.md
Name: keypad_request_queue

Overview:
- Consumes the keypad scanner outputs (4-bit key code `buttonBus`, `pressed`) and turns stable key presses into floor requests.
- De-duplicates requests against a pending-floor bitmap and buffers them in order in a FIFO.
- Presents the oldest live request to the motion controller over a valid/ready handshake.
- Also decodes two service keys: emergency stop and clear-all.

Parameters:
- NUM_FLOORS, 8, number of floors; key codes 0..NUM_FLOORS-1 are floor requests (legal range 2..14).
- DEPTH, 8, FIFO entries (power of two, ≥2).
- HOLD_CYCLES, 4, consecutive cycles a key code must be stable before it is accepted (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- buttonBus  in  4  key code from the keypad scanner; meaningful only while a key is held.
- pressed  in  1  low while a key is held, high when no key is held.
- req_ready  in  1  motion controller accepts `req_floor` this cycle.
- arrived  in  1  one-cycle pulse: car has arrived at `arrived_floor`.
- arrived_floor  in  $clog2(NUM_FLOORS)  floor reached.
- req_valid  out  1  `req_floor` holds a live request.
- req_floor  out  $clog2(NUM_FLOORS)  floor at the FIFO head.
- pending  out  NUM_FLOORS  bitmap of floors requested and not yet arrived.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- estop  out  1  emergency stop latched.
- overflow  out  1  one-cycle pulse: a new request was dropped because the FIFO was full.

Behaviour:
- Single clock `clk`; `rst` is asynchronous, active-high.
- Reset values: every output 0, FIFO empty, capture FSM in IDLE, hold counter 0.
- Key capture FSM (states IDLE, HOLD, WAIT_REL):
  - IDLE: if `pressed`==0, latch `buttonBus`, set hold_cnt=1, go to HOLD.
  - HOLD: if `pressed`==1, return to IDLE and emit no event (glitch reject).
  - HOLD: if `buttonBus` differs from the latched code, relatch it and set hold_cnt=1.
  - HOLD: otherwise increment hold_cnt. When hold_cnt==HOLD_CYCLES, emit key_event for exactly one cycle with the latched code and go to WAIT_REL.
  - HOLD_CYCLES==1: the event fires on the first HOLD cycle.
  - WAIT_REL: stay until `pressed`==1, then go to IDLE. A held key yields exactly one event, with no auto-repeat.
- Key decode, acting in the cycle after key_event:
  - code < NUM_FLOORS: floor request f.
  - 4'hF: set estop.
  - 4'hE: clear-all, which flushes the FIFO, sets `pending`=0 and clears estop in one cycle.
  - All other codes: ignored.
- Floor request f:
  - If `pending[f]`==1 (registered value), drop it silently.
  - Else if count==DEPTH, drop it and pulse `overflow`. Fullness is evaluated before any same-cycle pop, so a pop does not make room.
  - Else push f and set `pending[f]`.
- Arrival: `arrived` clears `pending[arrived_floor]` the next cycle. FIFO contents are untouched.
- Head handling:
  - If `pending[head]`==0 (a stale entry, already served en route), pop the head automatically. `req_valid` stays 0 that cycle; one stale entry is discarded per cycle.
  - Otherwise `req_valid` = (count>0) && !estop, and `req_floor` = head.
  - A transfer happens when `req_valid` && `req_ready` are both high; the head pops on that edge.
  - `pending[f]` stays set after the pop until arrival.
- estop: forces `req_valid`=0 and blocks pops. Floor requests are still queued. Only clear-all or reset clears estop.
- Simultaneous events:
  - Push and pop in one cycle: count unchanged, ordering preserved.
  - Arrival for f in the same cycle as a request for f: the request is dropped (pending was set) and the bit clears.
  - Clear-all overrides push, pop and arrival in that cycle.
- Pointers wrap modulo DEPTH; count is exact in 0..DEPTH.
- Latency: a key held steadily appears as `req_valid` = 1 at HOLD_CYCLES + 3 cycles after `pressed` falls, with an empty FIFO and no estop.
- Reset mid-operation: immediate return to reset values, and any in-progress key capture is discarded.

Test Plan:
- Hold key 3 for 6 cycles, then release -> one request; `req_floor`=3, `req_valid`=1 at HOLD_CYCLES+3, `pending`=8'b0000_1000; a release and re-press of 3 is dropped, count stays 1.
- Press 5, then drop `pressed` for 1 cycle mid-HOLD (hold 2 cycles, release) -> no event, count=0; a code change 2→6 mid-hold -> a single request for 6 only.
- Queue floors 1,2,3,4; pulse `arrived` with floor 2 while 1 is at head; handshake with `req_ready`=1 -> order seen 1, 3, 4 (2 skipped as stale); `pending` bits clear only on arrival pulses.
- DEPTH=8: queue floors 0..7, then press key 7 after arriving at 7 -> `overflow` pulses once, count stays 8; press 4'hA -> ignored, no overflow.
- Queue 2 requests, press 4'hF -> `req_valid`=0 with `req_ready`=1 held 10 cycles, count=2; press floor 6 -> count=3; press 4'hE -> count=0, `pending`=0, `estop`=0.
- Assert `rst` asynchronously mid-HOLD with count=3 -> all outputs 0 immediately, no event after deassert until a fresh press.
